// File: rtl/framebuffer.sv
// ---------------------------------------------------------------------------
// framebuffer
//   Simple dual-port frame store for a 320x240 RGB332 image. Entries are
//   row-major (address = y*FB_WIDTH + x). Pixel data is stored and returned
//   verbatim; coordinate scaling and colour expansion belong to the callers.
//
//   Port A: write-only, used by the renderer.
//   Port B: read-only, used by VGA scan-out. One-cycle registered read,
//           reads every cycle, with no enable.
//
// Ports
//   clk    : system clock; all state changes on its rising edge
//   reset  : synchronous active-high; clears doutb and blocks port A writes
//            for that cycle. Memory contents survive reset.
//   wea    : port A write enable
//   addra  : port A write address
//   dina   : port A write data
//   addrb  : port B read address
//   doutb  : port B registered read data
//
// Notes
//   - Addresses at or beyond DEPTH are outside the frame. Writes to them are
//     dropped, so there is no aliasing. Reads from them return zero.
//   - A write and a read to the same address in one cycle is read-first:
//     doutb returns the old contents.
//   - Memory powers up to all zeros through the declaration initialiser,
//     which becomes the BRAM init image in synthesis.
// ---------------------------------------------------------------------------
module framebuffer #(
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 240,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 17,
    parameter int DEPTH     = FB_WIDTH * FB_HEIGHT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    input  logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] doutb
);

    // The last valid address is kept at the port width. This keeps the
    // range compares the same width as the address inputs.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: '0};

    logic a_in_range;
    logic b_in_range;

    assign a_in_range = (addra <= LAST_ADDR);
    assign b_in_range = (addrb <= LAST_ADDR);

    // Port A write. Reset gates only the write strobe, not the array, so
    // the array can still map onto a plain BRAM write port.
    always_ff @(posedge clk) begin
        if (!reset && wea && a_in_range)
            mem[addra] <= dina;
    end

    // Port B read. The non-blocking read of mem gives read-first behaviour
    // against a same-cycle port A write.
    always_ff @(posedge clk) begin
        if (reset)
            doutb <= '0;
        else if (b_in_range)
            doutb <= mem[addrb];
        else
            doutb <= '0;
    end

endmodule

// File: tb/tb_framebuffer.sv
// ---------------------------------------------------------------------------
// tb_framebuffer
//   Scoreboard bench for framebuffer. The tick task drives one cycle of
//   stimulus. As it drives, it pushes the expected doutb onto exp_q, taken
//   from a reference memory before that cycle's write (read-first). Each
//   test pops and compares after the edge at which the read is registered.
//   The bulk fill covers the first FILL_ROWS rows so the run stays short.
// ---------------------------------------------------------------------------
module tb_framebuffer;

    localparam int FB_W      = 320;
    localparam int FB_H      = 240;
    localparam int DEPTH     = FB_W * FB_H;
    localparam int AW        = 17;
    localparam int FILL_ROWS = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          wea;
    logic [AW-1:0] addra;
    logic [7:0]    dina;
    logic [AW-1:0] addrb;
    logic [7:0]    doutb;

    logic [7:0] model [0:DEPTH-1];
    logic [7:0] exp_q [$];
    logic [7:0] exp;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    framebuffer dut (
        .clk   (clk),
        .reset (reset),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .addrb (addrb),
        .doutb (doutb)
    );

    // Drive one cycle. Push the expected read result and update the model.
    // Then advance to the following falling edge, where doutb is settled.
    task automatic tick(input logic rst, input logic we, input int wa,
                        input logic [7:0] wd, input int ra);
        reset = rst;
        wea   = we;
        addra = AW'(wa);
        dina  = wd;
        addrb = AW'(ra);
        if (rst)
            exp_q.push_back(8'h00);
        else if (ra < DEPTH)
            exp_q.push_back(model[ra]);
        else
            exp_q.push_back(8'h00);
        if (!rst && we && wa < DEPTH)
            model[wa] = wd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 0, 8'h00, i * 7000);
            exp = exp_q.pop_front(); n_cmp++;
            if (doutb !== exp || doutb !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_hold cyc%0d: doutb=%02h expected=00", i, doutb);
            end
        end
        tick(1'b0, 1'b0, 0, 8'h00, 0);
        exp = exp_q.pop_front(); n_cmp++;
        if (doutb !== exp) begin
            n_bad++;
            $display("FAIL powerup_addr0: doutb=%02h expected=%02h", doutb, exp);
        end
        tick(1'b0, 1'b0, 0, 8'h00, DEPTH - 1);
        exp = exp_q.pop_front(); n_cmp++;
        if (doutb !== exp) begin
            n_bad++;
            $display("FAIL powerup_addr76799: doutb=%02h expected=%02h", doutb, exp);
        end
    endtask

    task automatic test_single_write;
        int ra [3] = '{3210, 3209, 3211};
        tick(1'b0, 1'b1, 3210, 8'hE0, 0);
        exp = exp_q.pop_front(); n_cmp++;
        if (doutb !== exp) begin
            n_bad++;
            $display("FAIL single_wr_cycle: doutb=%02h expected=%02h", doutb, exp);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 0, 8'h00, ra[i]);
            exp = exp_q.pop_front(); n_cmp++;
            if (doutb !== exp) begin
                n_bad++;
                $display("FAIL single_rd addr=%0d: doutb=%02h expected=%02h", ra[i], doutb, exp);
            end
        end
    endtask

    task automatic test_collision;
        tick(1'b0, 1'b1, 500, 8'h03, 0);
        void'(exp_q.pop_front());
        tick(1'b0, 1'b1, 500, 8'h1C, 500);
        exp = exp_q.pop_front(); n_cmp++;
        if (doutb !== exp || doutb !== 8'h03) begin
            n_bad++;
            $display("FAIL collision_old: doutb=%02h expected=03", doutb);
        end
        tick(1'b0, 1'b0, 0, 8'h00, 500);
        exp = exp_q.pop_front(); n_cmp++;
        if (doutb !== exp || doutb !== 8'h1C) begin
            n_bad++;
            $display("FAIL collision_new: doutb=%02h expected=1c", doutb);
        end
    endtask

    task automatic test_out_of_range;
        int ra [4] = '{0, DEPTH - 1, DEPTH, 131071};
        tick(1'b0, 1'b1, DEPTH, 8'hFF, 0);
        void'(exp_q.pop_front());
        tick(1'b0, 1'b1, 131071, 8'hFF, 0);
        void'(exp_q.pop_front());
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 0, 8'h00, ra[i]);
            exp = exp_q.pop_front(); n_cmp++;
            if (doutb !== exp || doutb !== 8'h00) begin
                n_bad++;
                $display("FAIL oor addr=%0d: doutb=%02h expected=00", ra[i], doutb);
            end
        end
    endtask

    // Back-to-back writes every cycle. Port B reads the address being
    // written, so each compare also exercises read-first.
    task automatic test_fill_rect;
        int fill_n = FILL_ROWS * FB_W;
        for (int a = 0; a < fill_n; a++) begin
            tick(1'b0, 1'b1, a, 8'h01, a);
            exp = exp_q.pop_front(); n_cmp++;
            if (doutb !== exp) begin
                n_bad++;
                $display("FAIL fill_rf addr=%0d: doutb=%02h expected=%02h", a, doutb, exp);
            end
        end
        for (int y = 10; y <= 39; y++)
            for (int x = 10; x <= 59; x++) begin
                tick(1'b0, 1'b1, y * FB_W + x, 8'hE0, 0);
                void'(exp_q.pop_front());
            end
        for (int a = 0; a < fill_n; a++) begin
            tick(1'b0, 1'b0, 0, 8'h00, a);
            exp = exp_q.pop_front(); n_cmp++;
            if (doutb !== exp) begin
                n_bad++;
                $display("FAIL sweep addr=%0d: doutb=%02h expected=%02h", a, doutb, exp);
            end
        end
    endtask

    task automatic test_reset_midstream;
        int ra [5] = '{42, 100, 3210, 500, 20000};
        tick(1'b0, 1'b1, 100, 8'h5A, 42);
        void'(exp_q.pop_front());
        tick(1'b1, 1'b1, 42, 8'hAA, 42);
        exp = exp_q.pop_front(); n_cmp++;
        if (doutb !== exp || doutb !== 8'h00) begin
            n_bad++;
            $display("FAIL mid_reset_dout: doutb=%02h expected=00", doutb);
        end
        tick(1'b1, 1'b1, 43, 8'hAA, 100);
        exp = exp_q.pop_front(); n_cmp++;
        if (doutb !== exp) begin
            n_bad++;
            $display("FAIL mid_reset_dout2: doutb=%02h expected=%02h", doutb, exp);
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 0, 8'h00, ra[i]);
            exp = exp_q.pop_front(); n_cmp++;
            if (doutb !== exp) begin
                n_bad++;
                $display("FAIL post_reset addr=%0d: doutb=%02h expected=%02h", ra[i], doutb, exp);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        reset = 1'b1; wea = 1'b0; addra = '0; dina = '0; addrb = '0;
        test_reset();
        test_single_write();
        test_collision();
        test_out_of_range();
        test_fill_rect();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
